// File: rtl/alarm_timer_ctrl.sv
// Countdown timer for the car alarm: four programmable second-slots, one active
// countdown driven by a one-second prescaler, single-cycle expiry pulse.
module alarm_timer_ctrl #(
    parameter int          TICKS_PER_SEC = 50000000,
    parameter logic [3:0]  DEF_ARM       = 4'd6,
    parameter logic [3:0]  DEF_DRIVER    = 4'd8,
    parameter logic [3:0]  DEF_PASS      = 4'd15,
    parameter logic [3:0]  DEF_ALARM     = 4'd10
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    input  logic       start,
    input  logic [1:0] interval,
    output logic       busy,
    output logic       expired,
    output logic [3:0] remaining,
    output logic       sec_tick,
    output logic [1:0] dbg_state
);
    localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_COUNT = 2'd1, S_DONE = 2'd2} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;
    logic [3:0]    r_remaining;
    logic          r_expired;
    logic          r_sec_tick;
    logic [3:0]    r_slot [4];
    logic [3:0]    w_load;

    assign w_load    = r_slot[interval];
    assign busy      = (r_state == S_COUNT);
    assign expired   = r_expired;
    assign remaining = r_remaining;
    assign sec_tick  = r_sec_tick;
    assign dbg_state = r_state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot[0] <= DEF_ARM;
            r_slot[1] <= DEF_DRIVER;
            r_slot[2] <= DEF_PASS;
            r_slot[3] <= DEF_ALARM;
        end else if (reprogram) begin
            r_slot[time_param_sel] <= time_value;
        end
    end

    // A zero-length countdown spends one cycle in DONE with expired low, then pulses,
    // so its expiry lands one cycle after the start edge rather than on it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_presc     <= '0;
            r_remaining <= 4'd0;
            r_expired   <= 1'b0;
            r_sec_tick  <= 1'b0;
        end else begin
            r_expired  <= 1'b0;
            r_sec_tick <= 1'b0;
            if (reprogram) begin
                r_state     <= S_IDLE;
                r_presc     <= '0;
                r_remaining <= 4'd0;
            end else if (start) begin
                r_presc     <= '0;
                r_remaining <= w_load;
                r_state     <= (w_load == 4'd0) ? S_DONE : S_COUNT;
            end else begin
                case (r_state)
                    S_COUNT: begin
                        if (r_presc == P_LAST) begin
                            r_presc    <= '0;
                            r_sec_tick <= 1'b1;
                            if (r_remaining != 4'd0)
                                r_remaining <= r_remaining - 4'd1;
                            if (r_remaining <= 4'd1) begin
                                r_state   <= S_DONE;
                                r_expired <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + PW'(1);
                        end
                    end
                    S_DONE: begin
                        if (!r_expired)
                            r_expired <= 1'b1;
                        else
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_timer_ctrl.sv
// Self-checking bench for alarm_timer_ctrl with a one-second period of 4 cycles.
module tb_alarm_timer_ctrl;
    localparam int T = 4;

    logic       clock;
    logic       reset;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       start;
    logic [1:0] interval;
    logic       busy;
    logic       expired;
    logic [3:0] remaining;
    logic       sec_tick;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // Reference model: countdown described by its start edge and loaded seconds.
    int          cyc = 0;
    bit          m_active = 0;
    int          m_start = 0;
    int          m_v = 0;
    logic [3:0]  m_slot [4];
    logic [31:0] exp_q [$];
    logic [6:0]  e_vec;

    alarm_timer_ctrl #(.TICKS_PER_SEC(T)) dut (
        .clock(clock), .reset(reset), .reprogram(reprogram),
        .time_param_sel(time_param_sel), .time_value(time_value),
        .start(start), .interval(interval), .busy(busy), .expired(expired),
        .remaining(remaining), .sec_tick(sec_tick), .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_reset();
        m_active  = 0;
        exp_q.delete();
        m_slot[0] = 4'd6;
        m_slot[1] = 4'd8;
        m_slot[2] = 4'd15;
        m_slot[3] = 4'd10;
        e_vec     = '0;
    endtask

    task automatic apply_reset();
        reset = 1'b1; reprogram = 1'b0; start = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model across the edge, samples 1 time unit later.
    task automatic drive_edge(input logic rp, input logic [1:0] sel, input logic [3:0] val,
                              input logic st, input logic [1:0] iv);
        int el, span;
        logic e_busy, e_exp, e_tick;
        logic [3:0] e_rem;
        reprogram = rp; time_param_sel = sel; time_value = val; start = st; interval = iv;
        @(posedge clock);
        cyc++;
        if (rp) begin
            m_slot[sel] = val;
            m_active = 0;
            exp_q.delete();
        end else if (st) begin
            m_active = 1;
            m_start  = cyc;
            m_v      = int'(m_slot[iv]);
            exp_q.delete();
            exp_q.push_back((m_v == 0) ? cyc + 1 : cyc + m_v * T);
        end
        e_busy = 0; e_exp = 0; e_tick = 0; e_rem = 4'd0;
        if (m_active) begin
            el   = cyc - m_start;
            span = (m_v == 0) ? 1 : m_v * T;
            if (m_v > 0 && el < span) begin
                e_busy = 1;
                e_rem  = 4'(m_v - el / T);
                e_tick = (el > 0 && el % T == 0);
            end else if (m_v > 0 && el == span) begin
                e_tick = 1;
            end
            if (el >= span) m_active = 0;
        end
        if (exp_q.size() > 0 && exp_q[0] == 32'(cyc)) begin
            e_exp = 1;
            void'(exp_q.pop_front());
        end
        e_vec = {e_busy, e_exp, e_rem, e_tick};
        #1;
    endtask

    task automatic test_reset();
        time_param_sel = 2'd0; time_value = 4'd0; interval = 2'd0;
        apply_reset();
        checks++;
        if ({busy, expired, remaining, sec_tick} !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", {busy, expired, remaining, sec_tick}, 7'd0);
        end
        release_reset();
    endtask

    task automatic test_default_count();
        int e0, busy_n, exp_n, exp_at;
        busy_n = 0; exp_n = 0; exp_at = -1;
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd0);
        e0 = cyc;
        if (busy) busy_n++;
        checks++;
        if ({busy, expired, remaining, sec_tick} !== e_vec) begin
            errors++;
            $display("FAIL default_start got=%b exp=%b", {busy, expired, remaining, sec_tick}, e_vec);
        end
        for (int i = 0; i < 30; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (busy) busy_n++;
            if (expired) begin exp_n++; exp_at = cyc; end
            checks++;
            if ({busy, expired, remaining, sec_tick} !== e_vec) begin
                errors++;
                $display("FAIL default_cycle cyc=%0d got=%b exp=%b", cyc, {busy, expired, remaining, sec_tick}, e_vec);
            end
        end
        checks++;
        if (busy_n != 24) begin errors++; $display("FAIL default_busy_len got=%0d exp=24", busy_n); end
        checks++;
        if (exp_n != 1 || exp_at != e0 + 24) begin
            errors++;
            $display("FAIL default_expiry count=%0d at=%0d exp_count=1 exp_at=%0d", exp_n, exp_at, e0 + 24);
        end
    endtask

    task automatic test_reprogram_slot();
        int e0, ticks, exp_at;
        ticks = 0; exp_at = -1;
        drive_edge(1'b1, 2'd2, 4'd3, 1'b0, 2'd0);
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd2);
        e0 = cyc;
        for (int i = 0; i < 16; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (sec_tick) ticks++;
            if (expired) exp_at = cyc;
            checks++;
            if ({busy, expired, remaining, sec_tick} !== e_vec) begin
                errors++;
                $display("FAIL reprog_cycle cyc=%0d got=%b exp=%b", cyc, {busy, expired, remaining, sec_tick}, e_vec);
            end
        end
        checks++;
        if (ticks != 3 || exp_at != e0 + 12) begin
            errors++;
            $display("FAIL reprog_ticks ticks=%0d at=%0d exp_ticks=3 exp_at=%0d", ticks, exp_at, e0 + 12);
        end
    endtask

    task automatic test_zero_slot();
        int e0, exp_at;
        bit saw_busy;
        exp_at = -1; saw_busy = 0;
        drive_edge(1'b1, 2'd1, 4'd0, 1'b0, 2'd0);
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd1);
        e0 = cyc;
        if (busy) saw_busy = 1;
        if (expired) exp_at = cyc;
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (busy) saw_busy = 1;
            if (expired) exp_at = cyc;
            checks++;
            if ({busy, expired, remaining, sec_tick} !== e_vec) begin
                errors++;
                $display("FAIL zero_cycle cyc=%0d got=%b exp=%b", cyc, {busy, expired, remaining, sec_tick}, e_vec);
            end
        end
        checks++;
        if (saw_busy || exp_at != e0 + 1) begin
            errors++;
            $display("FAIL zero_latency busy_seen=%0d at=%0d exp_busy=0 exp_at=%0d", saw_busy, exp_at, e0 + 1);
        end
    endtask

    task automatic test_restart();
        int e1, exp_n, exp_at;
        exp_n = 0; exp_at = -1;
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd3);
        for (int i = 0; i < 20; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (expired) exp_n++;
        end
        checks++;
        if (remaining !== 4'd5) begin errors++; $display("FAIL restart_pre got=%0d exp=5", remaining); end
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd0);
        e1 = cyc;
        checks++;
        if (remaining !== 4'd6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_reload rem=%0d busy=%0d exp_rem=6 exp_busy=1", remaining, busy);
        end
        for (int i = 0; i < 30; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (expired) begin exp_n++; exp_at = cyc; end
            checks++;
            if ({busy, expired, remaining, sec_tick} !== e_vec) begin
                errors++;
                $display("FAIL restart_cycle cyc=%0d got=%b exp=%b", cyc, {busy, expired, remaining, sec_tick}, e_vec);
            end
        end
        checks++;
        if (exp_n != 1 || exp_at != e1 + 24) begin
            errors++;
            $display("FAIL restart_expiry count=%0d at=%0d exp_count=1 exp_at=%0d", exp_n, exp_at, e1 + 24);
        end
    endtask

    task automatic test_abort();
        int e0, exp_n, exp_at;
        exp_n = 0; exp_at = -1;
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd3);
        for (int i = 0; i < 8; i++) drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
        // reprogram with start held high: the write wins and the count is dropped
        drive_edge(1'b1, 2'd3, 4'd7, 1'b1, 2'd3);
        checks++;
        if (busy !== 1'b0 || remaining !== 4'd0 || expired !== 1'b0) begin
            errors++;
            $display("FAIL abort_now busy=%0d rem=%0d exp=%0d exp_all=0", busy, remaining, expired);
        end
        for (int i = 0; i < 50; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (expired || busy) exp_n++;
        end
        checks++;
        if (exp_n != 0) begin errors++; $display("FAIL abort_quiet active_cycles=%0d exp=0", exp_n); end
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd3);
        e0 = cyc;
        for (int i = 0; i < 32; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (expired) exp_at = cyc;
            checks++;
            if ({busy, expired, remaining, sec_tick} !== e_vec) begin
                errors++;
                $display("FAIL abort_newslot cyc=%0d got=%b exp=%b", cyc, {busy, expired, remaining, sec_tick}, e_vec);
            end
        end
        checks++;
        if (exp_at != e0 + 28) begin errors++; $display("FAIL abort_slot_value at=%0d exp=%0d", exp_at, e0 + 28); end
    endtask

    task automatic test_reset_mid();
        int e0, exp_at;
        exp_at = -1;
        drive_edge(1'b1, 2'd0, 4'd1, 1'b0, 2'd0);
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd3);
        for (int i = 0; i < 6; i++) drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
        apply_reset();
        checks++;
        if ({busy, expired, remaining, sec_tick} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=%b", {busy, expired, remaining, sec_tick}, 7'd0);
        end
        release_reset();
        drive_edge(1'b0, 2'd0, 4'd0, 1'b1, 2'd0);
        e0 = cyc;
        checks++;
        if (remaining !== 4'd6 || busy !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_start rem=%0d busy=%0d exp_rem=6 exp_busy=1", remaining, busy);
        end
        for (int i = 0; i < 30; i++) begin
            drive_edge(1'b0, 2'd0, 4'd0, 1'b0, 2'd0);
            if (expired) exp_at = cyc;
        end
        checks++;
        if (exp_at != e0 + 24) begin errors++; $display("FAIL reset_mid_expiry at=%0d exp=%0d", exp_at, e0 + 24); end
    endtask

    task automatic test_random();
        logic rp, st;
        for (int i = 0; i < 800; i++) begin
            rp = ($urandom_range(0, 24) == 0);
            st = ($urandom_range(0, 14) == 0);
            drive_edge(rp, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), st, 2'($urandom_range(0, 3)));
            checks++;
            if ({busy, expired, remaining, sec_tick} !== e_vec) begin
                errors++;
                $display("FAIL random cyc=%0d got=%b exp=%b", cyc, {busy, expired, remaining, sec_tick}, e_vec);
            end
        end
    endtask

    initial begin
        reset = 1'b1; reprogram = 1'b0; start = 1'b0;
        time_param_sel = 2'd0; time_value = 4'd0; interval = 2'd0;
        test_reset();
        test_default_count();
        test_reprogram_slot();
        test_zero_slot();
        test_restart();
        test_abort();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
